game_flow_ctrl: RTL

- Parametrised top-level game screen state machine for the minesweeper core; successor of the fixed-width screen state controller.
- Decodes a difficulty switch bank of configurable width into a level and a mine-generation count, and sequences START -> MAP_GEN -> PLAY -> VICTORY/FAIL.
- Adds button edge detection, a PAUSE state, an ERROR recovery path, a per-second play timer with optional time limit, and generator handshake outputs.
- Sits between the button/switch inputs and the map generator, board logic and display renderer.

---
 rtl/game_flow_ctrl_pkg.sv | 26 ++
 rtl/game_flow_ctrl_if.sv | 28 ++
 rtl/game_flow_ctrl_timer.sv | 42 ++++
 rtl/game_flow_ctrl.sv | 132 +++++++++++++
 4 files changed

// File: rtl/game_flow_ctrl_pkg.sv
// Shared definitions for the minesweeper game flow controller: screen state codes
// and default difficulty/timer constants.
package game_flow_ctrl_pkg;

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    GAME_START   = 3'd0,
    GAME_MAP_GEN = 3'd1,
    GAME_PLAY    = 3'd2,
    GAME_VICTORY = 3'd3,
    GAME_FAIL    = 3'd4,
    GAME_ERROR   = 3'd5,
    GAME_PAUSE   = 3'd6
  } game_state_e;

  localparam int unsigned DEF_DIFF_W     = 4;
  localparam int unsigned DEF_LVL_W      = 2;
  localparam int unsigned DEF_CNT_W      = 6;
  localparam int unsigned DEF_MINE_BASE  = 10;
  localparam int unsigned DEF_MINE_STEP  = 5;
  localparam int unsigned DEF_TIMER_W    = 10;
  localparam int unsigned DEF_TICK_DIV   = 100000000;
  localparam int unsigned DEF_TIME_LIMIT = 0;

endpackage

// File: rtl/game_flow_ctrl_if.sv
// Game-side bundle: board result in, screen state / generator handshake / timer status out.
interface game_flow_ctrl_if #(
  parameter int unsigned LVL_W   = 2,
  parameter int unsigned CNT_W   = 6,
  parameter int unsigned TIMER_W = 10
);
  import game_flow_ctrl_pkg::*;

  logic [1:0]         play_end_i;
  logic [STATE_W-1:0] screen_state_o;
  logic [LVL_W-1:0]   level_o;
  logic [CNT_W-1:0]   mine_num_o;
  logic               gen_start_o;
  logic               gen_active_o;
  logic [TIMER_W-1:0] elapsed_o;
  logic               timeout_o;

  modport master (
    input  play_end_i,
    output screen_state_o, level_o, mine_num_o, gen_start_o, gen_active_o, elapsed_o, timeout_o
  );

  modport slave (
    output play_end_i,
    input  screen_state_o, level_o, mine_num_o, gen_start_o, gen_active_o, elapsed_o, timeout_o
  );

endinterface

// File: rtl/game_flow_ctrl_timer.sv
// Play timer: tick prescaler plus saturating seconds counter with optional limit compare.
module game_timer #(
  parameter int unsigned TIMER_W    = 10,
  parameter int unsigned TICK_DIV   = 100000000,
  parameter int unsigned TIME_LIMIT = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               enable,
  output logic [TIMER_W-1:0] elapsed,
  output logic               limit_hit
);

  localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0]   PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [TIMER_W-1:0] LIMIT    = TIMER_W'(TIME_LIMIT);

  logic [PRE_W-1:0]   presc_q;
  logic [TIMER_W-1:0] elapsed_q;

  // Prescaler simply holds when disabled, so a paused partial second is kept.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      presc_q   <= '0;
      elapsed_q <= '0;
    end else if (enable) begin
      if (presc_q == PRE_LAST) begin
        presc_q <= '0;
        if (elapsed_q != '1) begin
          elapsed_q <= elapsed_q + 1'b1;
        end
      end else begin
        presc_q <= presc_q + 1'b1;
      end
    end
  end

  assign elapsed   = elapsed_q;
  assign limit_hit = (TIME_LIMIT != 0) && (elapsed_q == LIMIT);

endmodule

// File: rtl/game_flow_ctrl.sv
// Top-level minesweeper screen state machine: difficulty decode, map generation handshake,
// play/pause/result sequencing and per-second play timer.
module game_flow_ctrl
  import game_flow_ctrl_pkg::*;
#(
  parameter int unsigned DIFF_W     = DEF_DIFF_W,
  parameter int unsigned LVL_W      = DEF_LVL_W,
  parameter int unsigned CNT_W      = DEF_CNT_W,
  parameter int unsigned MINE_BASE  = DEF_MINE_BASE,
  parameter int unsigned MINE_STEP  = DEF_MINE_STEP,
  parameter int unsigned TIMER_W    = DEF_TIMER_W,
  parameter int unsigned TICK_DIV   = DEF_TICK_DIV,
  parameter int unsigned TIME_LIMIT = DEF_TIME_LIMIT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mid_button_i,
  input  logic              pause_button_i,
  input  logic [DIFF_W-1:0] difficulty_i,
  game_flow_ctrl_if.master  game
);

  game_state_e      state_q, state_d;
  logic             mid_q, pause_q;
  logic             mid_press, pause_press;
  logic [LVL_W-1:0] lvl_dec, level_q;
  logic [CNT_W-1:0] mine_dec, mine_q;
  logic [CNT_W-1:0] gen_cnt_q;
  logic             gen_start_q, gen_active_q, timeout_q;
  logic             timeout_set, enter_gen, limit_hit;

  assign mid_press   = mid_button_i & ~mid_q;
  assign pause_press = pause_button_i & ~pause_q;

  // Highest set switch wins; all-zero falls through to level 0.
  always_comb begin
    lvl_dec = '0;
    for (int unsigned i = 0; i < DIFF_W; i++) begin
      if (difficulty_i[i]) lvl_dec = LVL_W'(i);
    end
    mine_dec = CNT_W'(MINE_BASE + MINE_STEP * 32'(lvl_dec));
    if (mine_dec == '0) mine_dec = CNT_W'(1);
  end

  always_comb begin
    state_d     = state_q;
    timeout_set = 1'b0;
    case (state_q)
      GAME_START:   if (mid_press) state_d = GAME_MAP_GEN;
      GAME_MAP_GEN: if (gen_cnt_q == mine_q - 1'b1) state_d = GAME_PLAY;
      GAME_PLAY: begin
        if (game.play_end_i == 2'b11) begin
          state_d = GAME_ERROR;
        end else if (game.play_end_i == 2'b10) begin
          state_d = GAME_VICTORY;
        end else if (game.play_end_i == 2'b01) begin
          state_d = GAME_FAIL;
        end else if (limit_hit) begin
          state_d     = GAME_FAIL;
          timeout_set = 1'b1;
        end else if (pause_press) begin
          state_d = GAME_PAUSE;
        end
      end
      GAME_PAUSE: begin
        if (mid_press) begin
          state_d = GAME_START;
        end else if (pause_press) begin
          state_d = GAME_PLAY;
        end
      end
      GAME_VICTORY, GAME_FAIL, GAME_ERROR: if (mid_press) state_d = GAME_START;
      default: state_d = GAME_ERROR;
    endcase
  end

  assign enter_gen = (state_q == GAME_START) && (state_d == GAME_MAP_GEN);

  // Histories reset high so a button held through reset is not seen as a press.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= GAME_START;
      mid_q        <= 1'b1;
      pause_q      <= 1'b1;
      level_q      <= '0;
      mine_q       <= CNT_W'(MINE_BASE);
      gen_cnt_q    <= '0;
      gen_start_q  <= 1'b0;
      gen_active_q <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      mid_q        <= mid_button_i;
      pause_q      <= pause_button_i;
      gen_start_q  <= enter_gen;
      gen_active_q <= (state_d == GAME_MAP_GEN);
      if (enter_gen) begin
        level_q   <= lvl_dec;
        mine_q    <= mine_dec;
        gen_cnt_q <= '0;
      end else if (state_q == GAME_MAP_GEN) begin
        gen_cnt_q <= gen_cnt_q + 1'b1;
      end
      if (timeout_set) begin
        timeout_q <= 1'b1;
      end else if (state_d != GAME_FAIL) begin
        timeout_q <= 1'b0;
      end
    end
  end

  game_timer #(
    .TIMER_W   (TIMER_W),
    .TICK_DIV  (TICK_DIV),
    .TIME_LIMIT(TIME_LIMIT)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clear    (enter_gen),
    .enable   (state_q == GAME_PLAY),
    .elapsed  (game.elapsed_o),
    .limit_hit(limit_hit)
  );

  assign game.screen_state_o = state_q;
  assign game.level_o        = level_q;
  assign game.mine_num_o     = mine_q;
  assign game.gen_start_o    = gen_start_q;
  assign game.gen_active_o   = gen_active_q;
  assign game.timeout_o      = timeout_q;

endmodule
